// File: rtl/sysarr_ctrl.sv
// sysarr_ctrl: weight-load, skewed-stream and de-skew sequencer for an NxN
// weight-stationary systolic array. Define SYSARR_CTRL_RELU_EN to clamp negative sums.
module sysarr_ctrl #(
    parameter int WIDTH_HEIGHT = 2,
    parameter int ADDR_W       = 8,
    parameter int ARR_LAT      = 0
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            num_vecs,
    output logic                         busy,
    output logic                         done,
    output logic                         w_rd_en,
    output logic [ADDR_W-1:0]            w_rd_addr,
    input  logic [8*WIDTH_HEIGHT-1:0]    w_rd_data,
    output logic                         x_rd_en,
    output logic [ADDR_W-1:0]            x_rd_addr,
    input  logic [8*WIDTH_HEIGHT-1:0]    x_rd_data,
    output logic                         arr_active,
    output logic [8*WIDTH_HEIGHT-1:0]    arr_win,
    output logic [WIDTH_HEIGHT-1:0]      arr_wwrite,
    output logic [8*WIDTH_HEIGHT-1:0]    arr_datain,
    input  logic [16*WIDTH_HEIGHT-1:0]   arr_maccout,
    output logic                         res_valid,
    output logic [ADDR_W-1:0]            res_addr,
    output logic [16*WIDTH_HEIGHT-1:0]   res_data
);
    localparam int N  = WIDTH_HEIGHT;
    localparam int PD = 2 * N + ARR_LAT;

    typedef enum logic [2:0] {IDLE, LOADW, STREAM, DRAIN, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]    w_cnt_next;
    logic [ADDR_W-1:0]    r_m;
    logic [ADDR_W-1:0]    r_rcnt;
    logic                 r_wvalid;
    logic [PD-1:0]        r_vpipe;
    logic                 r_res_valid;
    logic [ADDR_W-1:0]    r_res_addr;
    logic [16*N-1:0]      r_res_data;
    logic [16*N-1:0]      w_res;
    logic                 w_last_res;

    assign w_last_res = r_res_valid && (r_res_addr == r_m - 1'b1);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next     = LOADW;
                    w_cnt_next = '0;
                end
            end
            LOADW: begin
                if (r_cnt == ADDR_W'(N - 1)) begin
                    w_cnt_next = '0;
                    w_next     = (r_m == '0) ? DRAIN : STREAM;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STREAM: begin
                if (r_cnt == r_m - 1'b1) begin
                    w_cnt_next = '0;
                    w_next     = DRAIN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (r_m == '0 || w_last_res) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign w_rd_en    = (r_state == LOADW);
    assign w_rd_addr  = w_rd_en ? ADDR_W'(N - 1) - r_cnt : '0;
    assign x_rd_en    = (r_state == STREAM);
    assign x_rd_addr  = x_rd_en ? r_cnt : '0;
    assign arr_wwrite = {N{r_wvalid}};
    assign arr_win    = r_wvalid ? w_rd_data : '0;
    // lane r carries valid data exactly r cycles after the read returned
    assign arr_active = |r_vpipe[N-1:0];
    assign res_valid  = r_res_valid;
    assign res_addr   = r_res_addr;
    assign res_data   = r_res_data;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_m         <= '0;
            r_rcnt      <= '0;
            r_wvalid    <= 1'b0;
            r_vpipe     <= '0;
            r_res_valid <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_wvalid    <= w_rd_en;
            r_vpipe     <= {r_vpipe[PD-2:0], x_rd_en};
            r_res_valid <= r_vpipe[PD-1];
            r_res_addr  <= r_vpipe[PD-1] ? r_rcnt : '0;
            r_res_data  <= r_vpipe[PD-1] ? w_res : '0;
            if (r_state == IDLE && start) begin
                r_m    <= num_vecs;
                r_rcnt <= '0;
            end else if (r_vpipe[PD-1]) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        logic [7:0] w_in;
        assign w_in = r_vpipe[0] ? x_rd_data[8*r +: 8] : 8'd0;
        if (r == 0) begin : g_d0
            assign arr_datain[7:0] = w_in;
        end else begin : g_dn
            logic [7:0] r_sk [r];
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_in;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign arr_datain[8*r +: 8] = r_sk[r-1];
        end
    end

    // column c arrives c cycles late, so it waits N-1-c to line up
    for (genvar c = 0; c < N; c++) begin : g_dsk
        localparam int DEP = N - 1 - c;
        logic [15:0] w_col;
        if (DEP == 0) begin : g_d0
            assign w_col = arr_maccout[16*c +: 16];
        end else begin : g_dn
            logic [15:0] r_ds [DEP];
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEP; i++) r_ds[i] <= '0;
                end else begin
                    r_ds[0] <= arr_maccout[16*c +: 16];
                    for (int i = 1; i < DEP; i++) r_ds[i] <= r_ds[i-1];
                end
            end
            assign w_col = r_ds[DEP-1];
        end
`ifdef SYSARR_CTRL_RELU_EN
        assign w_res[16*c +: 16] = w_col[15] ? 16'd0 : w_col;
`else
        assign w_res[16*c +: 16] = w_col;
`endif
    end
endmodule

// File: tb/tb_sysarr_ctrl.sv
// tb_sysarr_ctrl: buffer + array behavioural models, per-cycle schedule
// checker, directed cases and randomized jobs for sysarr_ctrl.
module tb_sysarr_ctrl;
    localparam int N  = 2;
    localparam int AW = 8;
    localparam int L  = 0;
    localparam int D  = 2 * N + 1 + L;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    num_vecs = '0;
    logic             busy, done, w_rd_en, x_rd_en, arr_active, res_valid;
    logic [AW-1:0]    w_rd_addr, x_rd_addr, res_addr;
    logic [8*N-1:0]   w_rd_data = '0;
    logic [8*N-1:0]   x_rd_data = '0;
    logic [8*N-1:0]   arr_win, arr_datain;
    logic [N-1:0]     arr_wwrite;
    logic [16*N-1:0]  arr_maccout = '0;
    logic [16*N-1:0]  res_data;

    sysarr_ctrl #(.WIDTH_HEIGHT(N), .ADDR_W(AW), .ARR_LAT(L)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .arr_active(arr_active), .arr_win(arr_win), .arr_wwrite(arr_wwrite),
        .arr_datain(arr_datain), .arr_maccout(arr_maccout),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [8*N-1:0] wmem [256];
    logic [8*N-1:0] xmem [256];
    logic signed [7:0] wa [N][N];
    logic [8*N-1:0] hist [64];
    bit  job_v = 0;
    int  t0 = 0;
    int  m = 0;
    int  nw = 0, nx = 0, nres = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int tdone();
        if (m == 0) return t0 + N + 2;
        return t0 + N + 1 + (m - 1) + D + 1;
    endfunction

    function automatic logic [16*N-1:0] expres(int k);
        logic [16*N-1:0]   v;
        int                acc;
        logic signed [7:0] a, b;
        logic [15:0]       s;
        v = '0;
        for (int c = 0; c < N; c++) begin
            acc = 0;
            for (int r = 0; r < N; r++) begin
                a = wmem[r][8*c +: 8];
                b = xmem[k][8*r +: 8];
                acc += a * b;
            end
            s = acc[15:0];
`ifdef SYSARR_CTRL_RELU_EN
            if (s[15]) s = 16'd0;
`endif
            v[16*c +: 16] = s;
        end
        return v;
    endfunction

    // buffers (1-cycle read latency) and array model
    always @(posedge clock) begin
        logic [16*N-1:0]   mac;
        logic signed [7:0] b;
        int                acc, idx;
        cyc++;
        w_rd_data <= w_rd_en ? wmem[w_rd_addr] : (8*N)'($urandom);
        x_rd_data <= x_rd_en ? xmem[x_rd_addr] : (8*N)'($urandom);
        mac = '0;
        for (int c = 0; c < N; c++) begin
            acc = 0;
            for (int r = 0; r < N; r++) begin
                idx = cyc - N - c - L + r;
                if (idx >= 0) begin
                    b = hist[idx % 64][8*r +: 8];
                    acc += wa[r][c] * b;
                end
            end
            mac[16*c +: 16] = acc[15:0];
        end
        arr_maccout <= mac;
    end

    // array capture plus schedule checker
    always @(negedge clock) begin
        logic ebusy, edone, ewen, ewwr, exen, eact, erv;
        logic [AW-1:0]   ewa, exa, era;
        logic [8*N-1:0]  ewin, edin;
        logic [16*N-1:0] erd;
        int rs, k, td;
        hist[cyc % 64] = arr_datain;
        if (&arr_wwrite) begin
            for (int r = N - 1; r > 0; r--)
                for (int c = 0; c < N; c++) wa[r][c] = wa[r-1][c];
            for (int c = 0; c < N; c++) wa[0][c] = arr_win[8*c +: 8];
        end
        if (w_rd_en) nw++;
        if (x_rd_en) nx++;
        if (res_valid) nres++;
        {ebusy, edone, ewen, ewwr, exen, eact, erv} = '0;
        ewa = '0; exa = '0; era = '0; ewin = '0; edin = '0; erd = '0;
        if (job_v) begin
            td = tdone();
            rs = t0 + N + 1;
            ebusy = (cyc > t0) && (cyc <= td);
            edone = (cyc == td);
            if (cyc >= t0 + 1 && cyc <= t0 + N) begin
                ewen = 1'b1;
                ewa  = AW'(N - 1 - (cyc - t0 - 1));
            end
            if (cyc >= t0 + 2 && cyc <= t0 + N + 1) begin
                ewwr = 1'b1;
                ewin = wmem[N - 1 - (cyc - t0 - 2)];
            end
            if (cyc >= rs && cyc < rs + m) begin
                exen = 1'b1;
                exa  = AW'(cyc - rs);
            end
            for (int r = 0; r < N; r++) begin
                k = cyc - rs - 1 - r;
                if (k >= 0 && k < m) begin
                    edin[8*r +: 8] = xmem[k][8*r +: 8];
                    eact = 1'b1;
                end
            end
            k = cyc - rs - D;
            if (k >= 0 && k < m) begin
                erv = 1'b1;
                era = AW'(k);
                erd = expres(k);
            end
        end
        chk("busy", busy, ebusy);
        chk("done", done, edone);
        chk("w_rd_en", w_rd_en, ewen);
        if (ewen) chk("w_rd_addr", w_rd_addr, ewa);
        chk("arr_wwrite", arr_wwrite, {N{ewwr}});
        chk("arr_win", arr_win, ewin);
        chk("x_rd_en", x_rd_en, exen);
        if (exen) chk("x_rd_addr", x_rd_addr, exa);
        chk("arr_datain", arr_datain, edin);
        chk("arr_active", arr_active, eact);
        chk("res_valid", res_valid, erv);
        if (erv) begin
            chk("res_addr", res_addr, era);
            chk("res_data", res_data, erd);
        end
    end

    task automatic launch(int mm);
        @(negedge clock); #1;
        start    = 1'b1;
        num_vecs = AW'(mm);
        if (!job_v || cyc > tdone()) begin
            job_v = 1; t0 = cyc; m = mm;
            nw = 0; nx = 0; nres = 0;
        end
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock); #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        chk("done_cyc", cyc, tdone());
        chk("n_wreads", nw, N);
        chk("n_xreads", nx, m);
        chk("n_results", nres, m);
        @(negedge clock); #1;
    endtask

    initial begin
        int lt0, mm;
        for (int i = 0; i < 256; i++) begin
            wmem[i] = '0;
            xmem[i] = '0;
        end
        for (int i = 0; i < 64; i++) hist[i] = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wa[r][c] = '0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_ctl", {busy, done, w_rd_en, x_rd_en, arr_active, res_valid}, 0);
        chk("rst_data", {arr_win, arr_wwrite, arr_datain, res_data, res_addr}, 0);
        rst_n = 1'b1;

        // single vector, literal result and timing
        wmem[0] = {8'd2, 8'd1};
        wmem[1] = {8'd4, 8'd3};
        xmem[0] = {8'd6, 8'd5};
        launch(1);
        lt0 = t0;
        repeat (lt0 + 8 - cyc) @(negedge clock);
        #1;
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 32'h0022_0017);
        @(negedge clock); #1;
        chk("t1_done", done, 1);
        @(negedge clock); #1;
        chk("t1_nres", nres, 1);

        // three back-to-back vectors with lane skew literals
        xmem[1] = {8'd2, 8'd1};
        xmem[2] = {8'd8, 8'd7};
        launch(3);
        lt0 = t0;
        repeat (lt0 + N + 2 - cyc) @(negedge clock);
        #1;
        chk("t2_lane_a", arr_datain, {8'd0, 8'd5});
        @(negedge clock); #1;
        chk("t2_lane_b", arr_datain, {8'd6, 8'd1});
        wait_done();

        // zero vectors
        launch(0);
        wait_done();

        // start while busy is ignored
        launch(3);
        @(negedge clock); #1;
        start = 1'b1; num_vecs = 8'd5;
        @(negedge clock); #1;
        start = 1'b0;
        wait_done();

        // reset mid stream
        launch(4);
        repeat (t0 + N + 2 - cyc) @(negedge clock);
        #2;
        rst_n = 1'b0;
        job_v = 0;
        #1;
        chk("arst_ctl", {busy, done, w_rd_en, x_rd_en, arr_active, res_valid}, 0);
        chk("arst_data", {arr_win, arr_wwrite, arr_datain, res_data, res_addr}, 0);
        repeat (2) @(negedge clock);
        #1;
        rst_n = 1'b1;
        launch(2);
        wait_done();

        // negative sums
        wmem[0] = {8'h00, 8'hFF};
        wmem[1] = {8'hFF, 8'h00};
        xmem[0] = {8'd4, 8'd3};
        launch(1);
        lt0 = t0;
        repeat (lt0 + 8 - cyc) @(negedge clock);
        #1;
        chk("relu_valid", res_valid, 1);
`ifdef SYSARR_CTRL_RELU_EN
        chk("relu_data", res_data, 32'h0000_0000);
`else
        chk("raw_data", res_data, 32'hFFFC_FFFD);
`endif
        wait_done();

        // randomized jobs
        for (int j = 0; j < 14; j++) begin
            for (int i = 0; i < N; i++) wmem[i] = (8*N)'($urandom);
            for (int i = 0; i < 8; i++) xmem[i] = (8*N)'($urandom);
            mm = $urandom_range(0, 6);
            launch(mm);
            if (mm > 0 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                #1;
                start = 1'b1; num_vecs = AW'($urandom_range(1, 7));
                @(negedge clock); #1;
                start = 1'b0;
            end
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
